streamcalc_ctrl: RTL and testbench
==================================

Name: streamcalc_ctrl

Overview:
Sequencer between the stream-calculator token input and the operand queue. Accepts one op token per valid/ready handshake and pre-checks queue occupancy against a local count. Computes ALU results from the queue head pair and drives the queue apply/op/in interface. Returns popped or peeked values on a result stream and latches a sticky error on underflow, overflow, illegal sequence or a queue-reported fault.

Parameters:
W, 8, data width; matches the queue data width
DEPTH, 11, queue capacity in entries; the local count saturates here

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
tok_valid  in  1  token present
tok_ready  out  1  controller can accept a token
tok_op  in  3  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 XOR, 5 PUSH, 6 POP, 7 PEEK
tok_data  in  W  operand for PUSH; ignored otherwise
q_apply  out  1  one-cycle queue command strobe
q_op  out  3  queue op code
q_in  out  W  queue write data
q_first  in  W  queue head
q_second  in  W  queue entry after the head
q_tail  in  W  queue tail
q_valid  in  1  queue status; 0 means the queue has faulted
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  W  result value
err  out  1  sticky error
err_clr  in  1  synchronous clear of the error state
count  out  4  local occupancy, 0..DEPTH

Behaviour:
- Reset values: state IDLE, count=0, q_apply=0, q_op=0, q_in=0, res_valid=0, res_data=0, err=0.
- FSM states: IDLE, ISSUE, EMIT, ERR.
- IDLE:
  - tok_ready=1.
  - On tok_valid&tok_ready, latch the op and run the legality check.
  - Ops 0-4 need count>=2; PUSH needs count<DEPTH; POP and PEEK need count>=1.
  - Illegal op -> ERR. No q_apply is issued and count is unchanged.
- Accept of a legal op (same edge):
  - Ops 0-4: q_in <= ALU(q_first, q_second), mod 2^W.
    - SUB is q_first-q_second.
    - MUL keeps the low W bits.
  - PUSH: q_in <= tok_data.
  - POP: res_data <= q_first.
  - PEEK: res_data <= q_tail.
  - Next state: ISSUE for ops 0-6; EMIT for PEEK.
- ISSUE:
  - Exactly one cycle with q_apply=1.
  - q_op = latched op; q_in holds its registered value.
  - count: ops 0-4 -1, PUSH +1, POP -1.
  - Next state: EMIT for POP, else IDLE.
  - tok_ready=0.
- EMIT:
  - res_valid=1 and res_data stable until res_ready.
  - On the handshake: res_valid<=0 and return to IDLE.
  - tok_ready=0.
- Latency: accept to q_apply is 1 cycle; POP accept to res_valid is 2 cycles; PEEK accept to res_valid is 1 cycle.
- Throughput: at most one token every 2 cycles.
- q_valid==0 sampled in any non-ERR state -> ERR at the next edge. Any in-flight result is dropped: res_valid<=0.
- ERR:
  - err=1, tok_ready=0, q_apply=0.
  - err_clr=1 -> IDLE, err<=0, count unchanged.
  - A queue fault needs rst_n for full recovery, because the queue's valid flag is sticky.
- err_clr outside ERR is ignored.
- rst_n asserted mid-ISSUE or mid-EMIT aborts immediately; all outputs take reset values.
- q_apply is never asserted in IDLE, EMIT or ERR.

Optional Feature:
STREAMCALC_SAT_EN
- Defined: ADD clamps to 2^W-1 on carry-out; SUB clamps to 0 on borrow; MUL clamps to 2^W-1 when any high product bit is set.
- Undefined: all three wrap modulo 2^W.
- AND, XOR and the sequencing are identical in both builds.

Test Plan:
1. Reset, then PUSH 3 and PUSH 5, then ADD, then POP -> q_apply pulses with ops 5,5,0,6; ADD drives q_in=8; POP gives res_data=8; count goes 1,2,1,0.
2. W=8: PUSH 200, PUSH 100, ADD, POP -> res_data=44 without STREAMCALC_SAT_EN, 255 with it.
3. count=0, then SUB token -> no q_apply, err=1, tok_ready=0; err_clr -> IDLE with count=0 and err=0.
4. PUSH ×11, then a 12th PUSH -> count=11, 12th push rejected, err=1, only 11 q_apply pulses seen.
5. PUSH 7, PUSH 9, PEEK with res_ready held low for 4 cycles -> res_valid=1 and res_data=9 stable across the stall; no q_apply; count stays 2.
6. Force q_valid=0 during EMIT -> ERR next cycle with res_valid=0; assert rst_n=0 mid-ISSUE -> q_apply=0 and all outputs at reset values.

Source files
------------

// File: rtl/streamcalc_ctrl.sv
// rtl/streamcalc_ctrl.sv - token sequencer between the stream calculator input and the operand queue
// Optional build macro STREAMCALC_SAT_EN: saturating ADD/SUB/MUL instead of modulo wrap.
module streamcalc_ctrl #(
  parameter int W     = 8,
  parameter int DEPTH = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [2:0]   tok_op,
  input  logic [W-1:0] tok_data,
  output logic         q_apply,
  output logic [2:0]   q_op,
  output logic [W-1:0] q_in,
  input  logic [W-1:0] q_first,
  input  logic [W-1:0] q_second,
  input  logic [W-1:0] q_tail,
  input  logic         q_valid,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         err,
  input  logic         err_clr,
  output logic [3:0]   count
);

  typedef enum logic [1:0] {IDLE, ISSUE, EMIT, ERR} state_t;

  localparam logic [2:0] OP_PUSH = 3'd5;
  localparam logic [2:0] OP_POP  = 3'd6;
  localparam logic [2:0] OP_PEEK = 3'd7;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  state_t         state, state_nx;
  logic [2:0]     op_r;
  logic [W-1:0]   q_in_r;
  logic [W-1:0]   res_r;
  logic [3:0]     cnt;
  logic           legal;
  logic           accept;
  logic [W:0]     sum;
  logic [W:0]     dif;
  logic [2*W-1:0] prod;
  logic [W-1:0]   alu;

  // Occupancy pre-check against the local count, not the queue itself.
  always_comb begin
    legal = 1'b0;
    case (tok_op)
      OP_PUSH:          legal = (cnt < DEPTH_C);
      OP_POP, OP_PEEK:  legal = (cnt != 4'd0);
      default:          legal = (cnt >= 4'd2);
    endcase
  end

  always_comb begin
    sum  = {1'b0, q_first} + {1'b0, q_second};
    dif  = {1'b0, q_first} - {1'b0, q_second};
    prod = {{W{1'b0}}, q_first} * {{W{1'b0}}, q_second};
    alu  = '0;
    case (tok_op)
      3'd0:    alu = sum[W-1:0];
      3'd1:    alu = dif[W-1:0];
      3'd2:    alu = prod[W-1:0];
      3'd3:    alu = q_first & q_second;
      3'd4:    alu = q_first ^ q_second;
      default: alu = '0;
    endcase
`ifdef STREAMCALC_SAT_EN
    if (tok_op == 3'd0 && sum[W])              alu = '1;
    if (tok_op == 3'd1 && dif[W])              alu = '0;
    if (tok_op == 3'd2 && |prod[2*W-1:W])      alu = '1;
`endif
  end

  assign accept = (state == IDLE) && tok_valid && q_valid && legal;

  always_comb begin
    state_nx  = state;
    tok_ready = 1'b0;
    q_apply   = 1'b0;
    res_valid = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid)
          state_nx = !legal ? ERR : (tok_op == OP_PEEK) ? EMIT : ISSUE;
      end
      ISSUE: begin
        q_apply  = 1'b1;
        state_nx = (op_r == OP_POP) ? EMIT : IDLE;
      end
      EMIT: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      ERR: begin
        err = 1'b1;
        if (err_clr) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // A queue fault overrides everything and drops any pending result.
    if (state != ERR && !q_valid) state_nx = ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_r   <= 3'd0;
      q_in_r <= '0;
      res_r  <= '0;
      cnt    <= 4'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_r <= tok_op;
        case (tok_op)
          OP_PUSH: q_in_r <= tok_data;
          OP_POP:  res_r  <= q_first;
          OP_PEEK: res_r  <= q_tail;
          default: q_in_r <= alu;
        endcase
      end
      if (state == ISSUE) begin
        if (op_r == OP_PUSH)      cnt <= cnt + 4'd1;
        else if (op_r != OP_PEEK) cnt <= cnt - 4'd1;
      end
    end
  end

  assign q_op     = op_r;
  assign q_in     = q_in_r;
  assign res_data = res_r;
  assign count    = cnt;

endmodule

// File: tb/tb_streamcalc_ctrl.sv
// tb/tb_streamcalc_ctrl.sv - self-checking bench for streamcalc_ctrl with a behavioural queue model
module tb_streamcalc_ctrl;
  localparam int W = 8;
  localparam int DEPTH = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic [2:0]   tok_op = 3'd0;
  logic [W-1:0] tok_data = '0;
  logic         q_apply;
  logic [2:0]   q_op;
  logic [W-1:0] q_in;
  logic [W-1:0] q_first = '0;
  logic [W-1:0] q_second = '0;
  logic [W-1:0] q_tail = '0;
  logic         q_valid = 1'b1;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         err;
  logic         err_clr = 1'b0;
  logic [3:0]   count;

  streamcalc_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_op(tok_op), .tok_data(tok_data), .q_apply(q_apply), .q_op(q_op),
    .q_in(q_in), .q_first(q_first), .q_second(q_second), .q_tail(q_tail),
    .q_valid(q_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .err(err), .err_clr(err_clr), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] d;
  } app_t;

  int           checks = 0;
  int           errors = 0;
  int           n_apply = 0;
  int           base;
  logic [W-1:0] mq[$];
  app_t         exp_app[$];
  logic [W-1:0] exp_res[$];
  logic [W-1:0] last_qin = '0;
  logic [W-1:0] last_res = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    int unsigned r;
    r = 0;
    case (op)
      3'd0: r = int'(a) + int'(b);
      3'd1: r = (a >= b) ? int'(a) - int'(b) : 32'(256 + int'(a) - int'(b));
      3'd2: r = int'(a) * int'(b);
      3'd3: r = int'(a & b);
      default: r = int'(a ^ b);
    endcase
`ifdef STREAMCALC_SAT_EN
    if (op == 3'd0 && r > 255) r = 255;
    if (op == 3'd1 && a < b) r = 0;
    if (op == 3'd2 && r > 255) r = 255;
`endif
    return r[W-1:0];
  endfunction

  // Queue model and scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (q_apply) begin
        n_apply++;
        last_qin = q_in;
        if (exp_app.size() == 0) chk("unexpected_apply", 32'(q_op), 32'hFFFF);
        else begin
          app_t e;
          e = exp_app.pop_front();
          chk("q_op", 32'(q_op), 32'(e.op));
          if (e.op != 3'd6) chk("q_in", 32'(q_in), 32'(e.d));
        end
        case (q_op)
          3'd5: mq.push_back(q_in);
          3'd6: void'(mq.pop_front());
          3'd7: ;
          default: begin
            void'(mq.pop_front());
            void'(mq.pop_front());
            mq.push_front(q_in);
          end
        endcase
      end
      if (res_valid && res_ready) begin
        last_res = res_data;
        if (exp_res.size() == 0) chk("unexpected_result", 32'(res_data), 32'hFFFF);
        else chk("res_data", 32'(res_data), 32'(exp_res.pop_front()));
      end
    end
    q_first  = (mq.size() > 0) ? mq[0] : '0;
    q_second = (mq.size() > 1) ? mq[1] : '0;
    q_tail   = (mq.size() > 0) ? mq[mq.size()-1] : '0;
  end

  task automatic do_reset();
    rst_n = 1'b0; tok_valid = 1'b0; err_clr = 1'b0; res_ready = 1'b1; q_valid = 1'b1;
    repeat (2) @(negedge clk);
    exp_app.delete();
    exp_res.delete();
    rst_n = 1'b1;
  endtask

  // Drives one token; returns just after the accepting edge.
  task automatic send(logic [2:0] op, logic [W-1:0] d);
    int t;
    int n;
    bit legal;
    t = 0;
    while (!tok_ready && t < 100) begin @(negedge clk); t++; end
    chk("tok_ready_wait", 32'(tok_ready), 1);
    n = mq.size();
    legal = (op <= 3'd4) ? (n >= 2) : (op == 3'd5) ? (n < DEPTH) : (n >= 1);
    if (legal) begin
      case (op)
        3'd5: exp_app.push_back({op, d});
        3'd6: begin exp_app.push_back({op, {W{1'b0}}}); exp_res.push_back(mq[0]); end
        3'd7: exp_res.push_back(mq[n-1]);
        default: exp_app.push_back({op, ref_alu(op, mq[0], mq[1])});
      endcase
    end
    tok_valid = 1'b1; tok_op = op; tok_data = d;
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!tok_ready && !err && t < 100) begin @(negedge clk); t++; end
    chk("idle_timeout", 32'(t < 100), 1);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    int t;
    // 1: reset values, then PUSH 3, PUSH 5, ADD, POP
    do_reset();
    chk("rst_tok_ready", 32'(tok_ready), 1);
    chk("rst_q_apply", 32'(q_apply), 0);
    chk("rst_q_op", 32'(q_op), 0);
    chk("rst_q_in", 32'(q_in), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_count", 32'(count), 0);
    base = n_apply;
    send(3'd5, 8'd3); wait_idle(); chk("t1_count1", 32'(count), 1);
    send(3'd5, 8'd5); wait_idle(); chk("t1_count2", 32'(count), 2);
    send(3'd0, 8'd0); wait_idle(); chk("t1_count3", 32'(count), 1);
    chk("t1_add_q_in", 32'(last_qin), 8);
    send(3'd6, 8'd0); wait_idle(); chk("t1_count4", 32'(count), 0);
    chk("t1_pop_res", 32'(last_res), 8);
    chk("t1_apply_pulses", 32'(n_apply - base), 4);

    // 2: ADD overflow, wraps or clamps
    send(3'd5, 8'd200); wait_idle();
    send(3'd5, 8'd100); wait_idle();
    send(3'd0, 8'd0);   wait_idle();
    send(3'd6, 8'd0);   wait_idle();
`ifdef STREAMCALC_SAT_EN
    chk("t2_add_ovf", 32'(last_res), 255);
`else
    chk("t2_add_ovf", 32'(last_res), 44);
`endif

    // 3: SUB on an empty queue
    base = n_apply;
    send(3'd1, 8'd0);
    @(negedge clk);
    chk("t3_err", 32'(err), 1);
    chk("t3_tok_ready", 32'(tok_ready), 0);
    chk("t3_no_apply", 32'(n_apply - base), 0);
    clear_err();
    chk("t3_err_clr", 32'(err), 0);
    chk("t3_idle", 32'(tok_ready), 1);
    chk("t3_count", 32'(count), 0);

    // 4: fill to DEPTH, then overflow
    base = n_apply;
    for (int i = 0; i < DEPTH; i++) begin send(3'd5, 8'(i + 1)); wait_idle(); end
    chk("t4_count_full", 32'(count), DEPTH);
    send(3'd5, 8'd99);
    @(negedge clk);
    chk("t4_err", 32'(err), 1);
    chk("t4_pulses", 32'(n_apply - base), DEPTH);
    chk("t4_count_hold", 32'(count), DEPTH);

    // 5: PEEK with a stalled consumer
    do_reset();
    send(3'd5, 8'd7); wait_idle();
    send(3'd5, 8'd9); wait_idle();
    base = n_apply;
    res_ready = 1'b0;
    send(3'd7, 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_res_valid", 32'(res_valid), 1);
      chk("t5_res_data", 32'(res_data), 9);
      chk("t5_no_apply", 32'(q_apply), 0);
    end
    res_ready = 1'b1;
    wait_idle();
    chk("t5_count", 32'(count), 2);
    chk("t5_no_pulses", 32'(n_apply - base), 0);
    chk("t5_peek_res", 32'(last_res), 9);

    // 6a: queue fault while a POP result is pending
    do_reset();
    send(3'd5, 8'd4); wait_idle();
    res_ready = 1'b0;
    send(3'd6, 8'd0);
    t = 0;
    while (!res_valid && t < 20) begin @(negedge clk); t++; end
    chk("t6_emit_reached", 32'(res_valid), 1);
    q_valid = 1'b0;
    @(negedge clk);
    chk("t6_fault_err", 32'(err), 1);
    chk("t6_fault_drop", 32'(res_valid), 0);
    exp_res.delete();

    // 6b: reset asserted in the middle of ISSUE
    do_reset();
    send(3'd5, 8'd1); wait_idle();
    send(3'd5, 8'd2); wait_idle();
    send(3'd0, 8'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_q_apply", 32'(q_apply), 0);
    chk("t6_rst_q_op", 32'(q_op), 0);
    chk("t6_rst_q_in", 32'(q_in), 0);
    chk("t6_rst_res_valid", 32'(res_valid), 0);
    chk("t6_rst_res_data", 32'(res_data), 0);
    chk("t6_rst_err", 32'(err), 0);
    chk("t6_rst_count", 32'(count), 0);
    exp_app.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("sb_apply_empty", 32'(exp_app.size()), 0);
    chk("sb_res_empty", 32'(exp_res.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
